// File: rtl/divisor_seq.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Divide-by-zero bypasses the iteration and reports all-ones / dividend with div_zero set.
module divisor_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] quociente,
    output logic [WIDTH-1:0] resto,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quociente_q, quociente_d;
    logic [WIDTH-1:0] resto_q, resto_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_next;
    logic             rem_ge;
    logic [WIDTH-1:0] quo_step;

    // Partial remainder is WIDTH+1 bits so the shifted value never overflows before the compare.
    assign rem_shift = {rem_q[WIDTH-1:0], dividend_q[cnt_q]};
    assign rem_ge    = (rem_shift >= {1'b0, divisor_q});
    assign rem_next  = rem_ge ? (rem_shift - {1'b0, divisor_q}) : rem_shift;

    always_comb begin
        quo_step        = quo_q;
        quo_step[cnt_q] = rem_ge;
    end

    always_comb begin
        state_d     = state_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        quociente_d = quociente_q;
        resto_d     = resto_q;
        div_zero_d  = div_zero_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dividend_d = A;
                    divisor_d  = B;
                    rem_d      = '0;
                    quo_d      = '0;
                    if (B == '0) begin
                        quociente_d = '1;
                        resto_d     = A;
                        div_zero_d  = 1'b1;
                        cnt_d       = '0;
                        state_d     = DONE;
                    end else begin
                        cnt_d      = CW'(WIDTH - 1);
                        div_zero_d = 1'b0;
                        state_d    = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = rem_next;
                quo_d = quo_step;
                if (cnt_q == '0) begin
                    quociente_d = quo_step;
                    resto_d     = rem_next[WIDTH-1:0];
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dividend_q  <= '0;
            divisor_q   <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            quociente_q <= '0;
            resto_q     <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            quociente_q <= quociente_d;
            resto_q     <= resto_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign quociente = quociente_q;
    assign resto     = resto_q;
    assign div_zero  = div_zero_q;
    assign busy      = (state_q == CALC);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_divisor_seq.sv
// Self-checking bench for divisor_seq (WIDTH=4) against a plain-arithmetic division model.
module tb_divisor_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A, B;
    logic [W-1:0] quociente, resto;
    logic         busy, done, div_zero;

    int errors = 0;
    int checks = 0;

    divisor_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
        .quociente(quociente), .resto(resto), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    // Reference: unsigned integer division; divide-by-zero yields all ones and the dividend.
    task automatic model(input int a, input int b, output int q, output int r, output int dz, output int lat, output int bc);
        if (b == 0) begin
            q = (1 << W) - 1; r = a; dz = 1; lat = 1; bc = 0;
        end else begin
            q = a / b; r = a % b; dz = 0; lat = W + 1; bc = W;
        end
    endtask

    // Launches one division; returns edges from acceptance to done and busy cycles seen.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, output int lat, output int bc, output logic ok);
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1; bc = 0; ok = 1'b0;
        while (lat <= 3 * W + 4) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) bc++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
        #1;
        checks++; if (quociente !== 4'd0) begin errors++; $display("FAIL reset_quociente got=%0d exp=0", quociente); end
        checks++; if (resto !== 4'd0) begin errors++; $display("FAIL reset_resto got=%0d exp=0", resto); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero got=%b exp=0", div_zero); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++; $display("FAIL idle_no_start busy=%b done=%b exp=0/0", busy, done);
            end
        end
    endtask

    task automatic test_basic();
        int lat, bc; logic ok;
        run_div(4'd13, 4'd4, lat, bc, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_timeout got=%b exp=1", ok); end
        checks++; if (lat != W + 1) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", lat, W + 1); end
        checks++; if (bc != W) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", bc, W); end
        checks++; if (quociente !== 4'd3 || resto !== 4'd1 || div_zero !== 1'b0) begin
            errors++; $display("FAIL basic_13_4 got q=%0d r=%0d dz=%b exp q=3 r=1 dz=0", quociente, resto, div_zero);
        end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_single_pulse got=%b exp=0", done); end
    endtask

    task automatic test_directed();
        int lat, bc; logic ok;
        int ta[3] = '{15, 3, 9};
        int tb[3] = '{1, 9, 9};
        int tq[3] = '{15, 0, 1};
        int tr[3] = '{0, 3, 0};
        for (int i = 0; i < 3; i++) begin
            run_div(W'(ta[i]), W'(tb[i]), lat, bc, ok);
            checks++;
            if (ok !== 1'b1 || quociente !== W'(tq[i]) || resto !== W'(tr[i]) || div_zero !== 1'b0) begin
                errors++;
                $display("FAIL directed_%0d_%0d got ok=%b q=%0d r=%0d dz=%b exp q=%0d r=%0d dz=0",
                         ta[i], tb[i], ok, quociente, resto, div_zero, tq[i], tr[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat, bc; logic ok;
        run_div(4'd7, 4'd0, lat, bc, ok);
        checks++; if (ok !== 1'b1 || lat != 1) begin errors++; $display("FAIL dz_latency got ok=%b lat=%0d exp lat=1", ok, lat); end
        checks++; if (bc != 0) begin errors++; $display("FAIL dz_busy got=%0d exp=0", bc); end
        checks++; if (quociente !== 4'hF || resto !== 4'd7 || div_zero !== 1'b1) begin
            errors++; $display("FAIL dz_result got q=%0d r=%0d dz=%b exp q=15 r=7 dz=1", quociente, resto, div_zero);
        end
        @(negedge clk);
        checks++; if (div_zero !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL dz_hold got dz=%b done=%b exp dz=1 done=0", div_zero, done);
        end
        run_div(4'd10, 4'd3, lat, bc, ok);
        checks++; if (div_zero !== 1'b0 || quociente !== 4'd3 || resto !== 4'd1) begin
            errors++; $display("FAIL dz_clear got q=%0d r=%0d dz=%b exp q=3 r=1 dz=0", quociente, resto, div_zero);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        A = 4'd11; B = 4'd3; start = 1'b1;
        @(negedge clk);
        n = 0;
        while (!done && n < 20) begin
            A = W'($urandom); B = W'($urandom);
            @(negedge clk); n++;
        end
        checks++; if (done !== 1'b1 || n != W) begin errors++; $display("FAIL held_first_done got done=%b n=%0d exp 1/%0d", done, n, W); end
        checks++; if (quociente !== 4'd3 || resto !== 4'd2) begin
            errors++; $display("FAIL held_first_result got q=%0d r=%0d exp q=3 r=2", quociente, resto);
        end
        A = 4'd15; B = 4'd4;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL held_idle got busy=%b done=%b exp 0/0", busy, done); end
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL held_restart got busy=%b exp=1", busy); end
        n = 0;
        while (!done && n < 20) begin
            checks++;
            if (quociente !== 4'd3 || resto !== 4'd2) begin
                errors++; $display("FAIL held_stable got q=%0d r=%0d exp q=3 r=2", quociente, resto);
            end
            A = W'($urandom); B = W'($urandom);
            @(negedge clk); n++;
        end
        start = 1'b0;
        checks++; if (done !== 1'b1 || quociente !== 4'd3 || resto !== 4'd3) begin
            errors++; $display("FAIL held_second got done=%b q=%0d r=%0d exp 1 q=3 r=3", done, quociente, resto);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_calc();
        int lat, bc; logic ok; int seen;
        run_div(4'd7, 4'd0, lat, bc, ok);
        @(negedge clk);
        A = 4'd13; B = 4'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (quociente !== 4'd0 || resto !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
            errors++; $display("FAIL midcalc_reset got q=%0d r=%0d busy=%b done=%b dz=%b exp all 0",
                               quociente, resto, busy, done, div_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midcalc_no_done got=%0d exp=0", seen); end
        run_div(4'd10, 4'd3, lat, bc, ok);
        checks++; if (ok !== 1'b1 || quociente !== 4'd3 || resto !== 4'd1) begin
            errors++; $display("FAIL midcalc_after got ok=%b q=%0d r=%0d exp q=3 r=1", ok, quociente, resto);
        end
    endtask

    task automatic test_exhaustive();
        int lat, bc, q, r, dz, el, eb; logic ok;
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                run_div(W'(a), W'(b), lat, bc, ok);
                model(a, b, q, r, dz, el, eb);
                checks++;
                if (ok !== 1'b1 || quociente !== W'(q) || resto !== W'(r) || div_zero !== dz[0] || lat != el || bc != eb) begin
                    errors++;
                    $display("FAIL sweep_%0d_%0d got q=%0d r=%0d dz=%b lat=%0d busy=%0d exp q=%0d r=%0d dz=%0d lat=%0d busy=%0d",
                             a, b, quociente, resto, div_zero, lat, bc, q, r, dz, el, eb);
                end
                if (b != 0) begin
                    checks++;
                    if ((int'(quociente) * b + int'(resto)) != a || int'(resto) >= b) begin
                        errors++; $display("FAIL sweep_identity_%0d_%0d got q=%0d r=%0d", a, b, quociente, resto);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        int lat, bc, q, r, dz, el, eb; logic ok;
        int a, b;
        for (int i = 0; i < 60; i++) begin
            a = int'($urandom_range(0, (1 << W) - 1));
            b = int'($urandom_range(0, (1 << W) - 1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_div(W'(a), W'(b), lat, bc, ok);
            model(a, b, q, r, dz, el, eb);
            checks++;
            if (ok !== 1'b1 || quociente !== W'(q) || resto !== W'(r) || div_zero !== dz[0] || lat != el) begin
                errors++;
                $display("FAIL random_%0d_%0d got q=%0d r=%0d dz=%b lat=%0d exp q=%0d r=%0d dz=%0d lat=%0d",
                         a, b, quociente, resto, div_zero, lat, q, r, dz, el);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_directed();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_calc();
        test_exhaustive();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/divisor_seq.md
DIVISOR_SEQ -- requirements
Module: divisor_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand, quotient and remainder width in bits (legal range 2..8).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, request to begin a division; sampled only in state IDLE.
REQ-005 SHALL have port A, input, WIDTH, the unsigned dividend; sampled on the accepting edge only.
REQ-006 SHALL have port B, input, WIDTH, the unsigned divisor; sampled on the accepting edge only.
REQ-007 SHALL have port quociente, output, WIDTH, the registered quotient.
REQ-008 SHALL have port resto, output, WIDTH, the registered remainder.
REQ-009 SHALL have port busy, output, 1, high while the state is CALC.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse that is high while the state is DONE.
REQ-011 SHALL have port div_zero, output, 1, error flag; valid while done=1 and held until the next accepted start.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, CALC and DONE.
REQ-013 SHALL accept a start on the edge where state=IDLE and start=1.
- Accepting with B!=0: latch A and B, clear the partial remainder (WIDTH+1 bits) and the quotient, load the bit counter with WIDTH-1, clear div_zero, and go to CALC.
REQ-014 SHALL handle an accepted start with B=0 as follows:
- go directly to DONE;
- load quociente with all ones and resto with A;
- set div_zero=1;
- perform no CALC cycles.
REQ-015 SHALL perform one restoring step on each CALC edge, MSB first:
- rem = {rem[WIDTH-1:0], dividend[counter]};
- if rem >= divisor: rem = rem - divisor and the quotient bit at position counter = 1;
- otherwise: the quotient bit = 0.
REQ-016 SHALL compute rem >= divisor as an unsigned compare over WIDTH+1 bits; equality counts as greater-or-equal.
REQ-017 SHALL decrement the counter on each CALC edge and go to DONE on the edge where counter=0, giving exactly WIDTH CALC cycles.
REQ-018 SHALL give a latency of WIDTH+1 edges from the accepting edge to done=1 for a nonzero divisor, and 1 edge for a zero divisor.
REQ-019 SHALL leave DONE for IDLE unconditionally after one cycle, so that done is never high for two consecutive cycles.
REQ-020 SHALL ignore start while in CALC or DONE; the operands latched at acceptance are not disturbed.
REQ-021 SHALL accept a start asserted in the first IDLE cycle after DONE, so back-to-back divisions take a minimum period of WIDTH+2 cycles.
REQ-022 SHALL update quociente and resto only on the edge entering DONE, and hold them stable at all other times, including during the next CALC.
REQ-023 SHALL write resto as the low WIDTH bits of rem; bit WIDTH of rem is always 0 at DONE.
REQ-024 SHALL guarantee quociente*B + resto = A and resto < B for every B!=0.
REQ-025 SHALL keep busy=0 in IDLE and DONE, and busy=1 in CALC only.

Reset
REQ-026 SHALL, when rst_n=0, immediately and without waiting for clk force: state=IDLE, quociente=0, resto=0, busy=0, done=0, div_zero=0, counter=0, and internal registers=0.
REQ-027 SHALL, on a reset asserted mid-CALC, abandon the division, produce no done pulse, and leave the results cleared to 0.
REQ-028 SHALL leave IDLE on the first rising clk edge after rst_n deasserts only if start=1 at that edge.

Verification
REQ-029 SHALL be covered by the scenario: WIDTH=4, A=13, B=4, start pulse -> busy high for 4 cycles, then done=1 with quociente=3, resto=1, div_zero=0.
REQ-030 SHALL be covered by the scenario: A=15, B=1 -> quociente=15, resto=0; then A=3, B=9 -> quociente=0, resto=3; then A=9, B=9 -> quociente=1, resto=0.
REQ-031 SHALL be covered by the scenario: A=7, B=0 -> done=1 one edge after acceptance, busy never high, quociente=4'hF, resto=7, div_zero=1; the next valid division clears div_zero.
REQ-032 SHALL be covered by the scenario: start held high continuously with new A/B applied during CALC -> the results reflect the operands latched at acceptance, and a new division starts on the first IDLE edge after DONE.
REQ-033 SHALL be covered by the scenario: rst_n pulsed low in the 2nd CALC cycle of 13/4 -> all outputs 0 asynchronously, no done pulse; a following 10/3 yields quociente=3, resto=1.
REQ-034 SHALL be covered by an exhaustive sweep of all 256 A/B pairs at WIDTH=4, checking REQ-024 at every done pulse, or div_zero=1 whenever B=0.
